// File: rtl/mod_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_updown_counter
//  Description : Parametrised up/down counter with programmable modulo,
//                synchronous load (clamped to modulo), wrap or saturate
//                boundary handling, registered terminal-count pulse and a
//                combinational at-limit flag. An optional clock-enable
//                prescaler is compiled in when COUNTER_PRESCALE_EN is defined.
//
//  Parameters  : WIDTH    - counter width in bits (>= 2)
//                PS_BITS  - prescaler width in bits (prescaler build only)
//
//  Ports       : clk       in   rising-edge clock
//                rst_n     in   asynchronous active-low reset
//                en        in   count enable
//                dir       in   1 = count up, 0 = count down
//                sat       in   1 = saturate at boundary, 0 = wrap
//                load      in   synchronous load strobe (beats a tick)
//                load_val  in   [WIDTH]   value to load, clamped to modulo
//                modulo    in   [WIDTH]   upper bound, range is 0..modulo
//                prescale  in   [PS_BITS] tick divider N = prescale+1
//                                         (COUNTER_PRESCALE_EN only)
//                count     out  [WIDTH]   registered count
//                tc        out  registered one-cycle terminal-count pulse
//                at_limit  out  combinational boundary flag for current dir
//
//  Build macro : COUNTER_PRESCALE_EN - adds the prescale port and prescaler
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_updown_counter #(
   parameter int WIDTH   = 8,
   parameter int PS_BITS = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               dir,
   input  logic               sat,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_val,
   input  logic [WIDTH-1:0]   modulo,
`ifdef COUNTER_PRESCALE_EN
   input  logic [PS_BITS-1:0] prescale,
`endif
   output logic [WIDTH-1:0]   count,
   output logic               tc,
   output logic               at_limit
);

   localparam logic [WIDTH-1:0] c_zero = '0;
   localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

   // Elaboration-time parameter sanity check.
   if (WIDTH < 2 || PS_BITS < 1) begin : g_param_check
      $error("mod_updown_counter: WIDTH must be >= 2 and PS_BITS >= 1");
   end

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_tc_nxt;
   logic [WIDTH-1:0] w_load_clamped;
   logic             w_tick;

   // -------------------------------------------------------------------------
   // Tick qualification
   // -------------------------------------------------------------------------
`ifdef COUNTER_PRESCALE_EN
   logic [PS_BITS-1:0] r_ps;
   logic               w_ps_hit;

   // Equality rather than >= : if prescale is lowered below the current
   // phase, ps runs on and wraps through zero before it can match again.
   assign w_ps_hit = (r_ps == prescale);
   assign w_tick   = en & w_ps_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ps <= '0;
      end else if (load) begin
         r_ps <= '0;
      end else if (en) begin
         r_ps <= w_ps_hit ? '0 : r_ps + 1'b1;
      end
   end
`else
   assign w_tick = en;
`endif

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_load_clamped = (load_val > modulo) ? modulo : load_val;
      w_count_nxt    = r_count;
      w_tc_nxt       = 1'b0;

      if (load) begin
         w_count_nxt = w_load_clamped;
      end else if (w_tick) begin
         if (dir) begin
            // Up: anything at or above modulo is a boundary event, which
            // also pulls an out-of-range count back after modulo drops.
            if (r_count < modulo) begin
               w_count_nxt = r_count + c_one;
            end else begin
               w_tc_nxt    = 1'b1;
               w_count_nxt = sat ? modulo : c_zero;
            end
         end else begin
            // Down: an out-of-range count snaps to modulo without tc.
            if (r_count > modulo) begin
               w_count_nxt = modulo;
            end else if (r_count == c_zero) begin
               w_tc_nxt    = 1'b1;
               w_count_nxt = sat ? c_zero : modulo;
            end else begin
               w_count_nxt = r_count - c_one;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= c_zero;
         r_tc    <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_tc    <= w_tc_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign count    = r_count;
   assign tc       = r_tc;
   assign at_limit = dir ? (r_count >= modulo) : (r_count == c_zero);

endmodule
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_updown_counter
//  Description : Scoreboard bench for mod_updown_counter. Directed vectors
//                push hand-computed expectations into a queue; a monitor
//                pops and compares after every clock edge. A WIDTH=8 and a
//                WIDTH=2 instance are exercised.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_updown_counter;

   typedef struct {
      logic [7:0] c;
      logic       t;
      logic       a;
      string      nm;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       en, dir, sat, load;
   logic [7:0] load_val, modulo;
   logic [7:0] count;
   logic       tc, at_limit;

   logic       en2, dir2, sat2, load2;
   logic [1:0] load_val2, modulo2;
   logic [1:0] count2;
   logic       tc2, at_limit2;

`ifdef COUNTER_PRESCALE_EN
   logic [3:0] prescale;
`endif

   int total = 0;
   int bad   = 0;

   exp_t q1[$];
   exp_t q2[$];

   mod_updown_counter #(.WIDTH(8), .PS_BITS(4)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .dir      (dir),
      .sat      (sat),
      .load     (load),
      .load_val (load_val),
      .modulo   (modulo),
`ifdef COUNTER_PRESCALE_EN
      .prescale (prescale),
`endif
      .count    (count),
      .tc       (tc),
      .at_limit (at_limit)
   );

   mod_updown_counter #(.WIDTH(2), .PS_BITS(4)) u_dut2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en2),
      .dir      (dir2),
      .sat      (sat2),
      .load     (load2),
      .load_val (load_val2),
      .modulo   (modulo2),
`ifdef COUNTER_PRESCALE_EN
      .prescale (4'd0),
`endif
      .count    (count2),
      .tc       (tc2),
      .at_limit (at_limit2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Monitors: one expectation per clock edge while the queue holds one.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q1.size() > 0) begin
         e = q1.pop_front();
         total++;
         if (count !== e.c || tc !== e.t || at_limit !== e.a) begin
            bad++;
            $display("FAIL %s: got count=%0d tc=%0b at_limit=%0b, want count=%0d tc=%0b at_limit=%0b",
                     e.nm, count, tc, at_limit, e.c, e.t, e.a);
         end
      end
   end

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q2.size() > 0) begin
         e = q2.pop_front();
         total++;
         if ({6'd0, count2} !== e.c || tc2 !== e.t || at_limit2 !== e.a) begin
            bad++;
            $display("FAIL %s: got count=%0d tc=%0b at_limit=%0b, want count=%0d tc=%0b at_limit=%0b",
                     e.nm, count2, tc2, at_limit2, e.c, e.t, e.a);
         end
      end
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, req);
      end
   endtask

   // Drive one cycle of inputs at the falling edge; the expected state is
   // what the DUT shows after the next rising edge.
   task automatic step(input logic e, input logic d, input logic s, input logic l,
                       input logic [7:0] lv, input logic [7:0] m,
                       input logic [7:0] xc, input logic xt, input logic xa,
                       input string nm);
      exp_t x;
      @(negedge clk);
      rst_n = 1'b1;
      en = e; dir = d; sat = s; load = l; load_val = lv; modulo = m;
      x.c = xc; x.t = xt; x.a = xa; x.nm = nm;
      q1.push_back(x);
   endtask

   task automatic step2(input logic e, input logic d, input logic s, input logic l,
                        input logic [1:0] lv, input logic [1:0] m,
                        input logic [7:0] xc, input logic xt, input logic xa,
                        input string nm);
      exp_t x;
      @(negedge clk);
      rst_n = 1'b1;
      en2 = e; dir2 = d; sat2 = s; load2 = l; load_val2 = lv; modulo2 = m;
      x.c = xc; x.t = xt; x.a = xa; x.nm = nm;
      q2.push_back(x);
   endtask

   // Assert reset between edges and check it acts without a clock edge.
   // Reset stays low until the next step releases it.
   task automatic reset_mid(input string nm, input logic xa);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk({nm, "_count"}, count, 8'd0);
      chk({nm, "_tc"}, {7'd0, tc}, 8'd0);
      chk({nm, "_at_limit"}, {7'd0, at_limit}, {7'd0, xa});
   endtask

   initial begin
      rst_n = 1'b0;
      en = 0; dir = 0; sat = 0; load = 0; load_val = 0; modulo = 0;
      en2 = 0; dir2 = 0; sat2 = 0; load2 = 0; load_val2 = 0; modulo2 = 0;
`ifdef COUNTER_PRESCALE_EN
      prescale = 4'd0;
`endif
      #2;
      chk("por_count", count, 8'd0);
      chk("por_tc", {7'd0, tc}, 8'd0);
      chk("por_at_limit_dn", {7'd0, at_limit}, 8'd1);
      chk("por_count2", {6'd0, count2}, 8'd0);

      // Count to 5, then reset mid-count.
      step(1,1,0,0,0,9, 1,0,0, "first_up");
      for (int i = 2; i <= 5; i++) step(1,1,0,0,0,9, 8'(i),0,0, "up_to5");
      reset_mid("rst_at5", 1'b0);

      // Wrap up through modulo 9.
      step(1,1,0,0,0,9, 1,0,0, "rel_first");
      for (int i = 2; i <= 9; i++) step(1,1,0,0,0,9, 8'(i),0,(i == 9), "wrap_up");
      step(1,1,0,0,0,9, 0,1,0, "wrap_to0");
      step(1,1,0,0,0,9, 1,0,0, "after_wrap");
      step(0,1,0,0,0,9, 1,0,0, "en_low_hold");

      // Saturate down, then wrap down.
      step(0,0,1,1,2,9, 2,0,0, "load2");
      step(1,0,1,0,0,9, 1,0,0, "satdn1");
      step(1,0,1,0,0,9, 0,0,1, "satdn0");
      step(1,0,1,0,0,9, 0,1,1, "satdn_hold_a");
      step(1,0,1,0,0,9, 0,1,1, "satdn_hold_b");
      step(1,0,0,0,0,9, 9,1,0, "dnwrap");
      step(1,0,0,0,0,9, 8,0,0, "dn8");

      // Saturate up.
      step(0,1,1,1,8,9, 8,0,0, "load8");
      step(1,1,1,0,0,9, 9,0,1, "satup9");
      step(1,1,1,0,0,9, 9,1,1, "satup_hold_a");
      step(1,1,1,0,0,9, 9,1,1, "satup_hold_b");

      // Load priority, clamp and lowered modulo.
      step(1,1,0,1,200,50, 50,0,1, "load_clamp");
      step(1,1,0,0,0,20, 0,1,0, "lower_mod_wrap");
      step(1,1,1,1,200,50, 50,0,1, "load_clamp_s");
      step(1,1,1,0,0,20, 20,1,1, "lower_mod_sat");
      step(1,0,0,1,200,50, 50,0,0, "load_clamp_dn");
      step(1,0,0,0,0,20, 20,0,0, "dn_above_mod");
      step(1,0,0,0,0,20, 19,0,0, "dn19");
      step(0,1,0,1,50,50, 50,0,1, "load50");
      step(0,1,0,0,0,20, 50,0,1, "mod_lower_idle");

      // modulo = 0.
      step(1,1,0,0,0,0, 0,1,1, "mod0_a");
      step(1,1,0,0,0,0, 0,1,1, "mod0_b");
      step(1,0,0,0,0,0, 0,1,1, "mod0_dn");
      step(1,0,1,0,0,0, 0,1,1, "mod0_dn_sat");
      step(0,0,0,0,0,0, 0,0,1, "mod0_idle");

      // Load below modulo and full-width wrap.
      step(0,1,0,1,7,9, 7,0,0, "load7");
      step(0,1,0,1,254,255, 254,0,0, "load254");
      step(1,1,0,0,0,255, 255,0,1, "up255");
      step(1,1,0,0,0,255, 0,1,0, "wrap255");
      step(1,0,0,0,0,255, 255,1,0, "dnwrap255");

      // Reset while tc is high.
      step(1,1,0,1,9,9, 9,0,1, "load9");
      step(1,1,0,0,0,9, 0,1,0, "tc_before_rst");
      reset_mid("rst_tc", 1'b0);
      step(1,1,0,0,0,9, 1,0,0, "rel_second");

`ifdef COUNTER_PRESCALE_EN
      @(posedge clk);
      #2;
      prescale = 4'd3;
      step(0,1,0,1,0,9, 0,0,0, "ps_load");
      step(1,1,0,0,0,9, 0,0,0, "ps_a1");
      step(1,1,0,0,0,9, 0,0,0, "ps_a2");
      step(1,1,0,0,0,9, 0,0,0, "ps_a3");
      step(1,1,0,0,0,9, 1,0,0, "ps_a4");
      step(1,1,0,0,0,9, 1,0,0, "ps_b1");
      step(1,1,0,0,0,9, 1,0,0, "ps_b2");
      step(0,1,0,0,0,9, 1,0,0, "ps_b_gap1");
      step(0,1,0,0,0,9, 1,0,0, "ps_b_gap2");
      step(1,1,0,0,0,9, 1,0,0, "ps_b3");
      step(1,1,0,0,0,9, 2,0,0, "ps_b4");
      step(1,1,0,0,0,9, 2,0,0, "ps_c1");
      step(1,1,0,0,0,9, 2,0,0, "ps_c2");
      step(1,1,0,1,5,9, 5,0,0, "ps_reload");
      step(1,1,0,0,0,9, 5,0,0, "ps_d1");
      step(1,1,0,0,0,9, 5,0,0, "ps_d2");
      step(1,1,0,0,0,9, 5,0,0, "ps_d3");
      step(1,1,0,0,0,9, 6,0,0, "ps_d4");
`endif

      // WIDTH=2 instance: down wrap with modulo 3, then saturate up.
      step2(1,0,0,0,0,3, 3,1,0, "w2_dn3");
      step2(1,0,0,0,0,3, 2,0,0, "w2_dn2");
      step2(1,0,0,0,0,3, 1,0,0, "w2_dn1");
      step2(1,0,0,0,0,3, 0,0,1, "w2_dn0");
      step2(1,0,0,0,0,3, 3,1,0, "w2_dnwrap");
      step2(1,1,1,0,0,3, 3,1,1, "w2_satup");
      step2(0,1,0,1,2,1, 1,0,1, "w2_load_clamp");

      // Drain the scoreboards within a bounded number of cycles.
      for (int i = 0; i < 10 && (q1.size() > 0 || q2.size() > 0); i++) @(posedge clk);
      #3;
      if (q1.size() > 0 || q2.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending, want 0", q1.size() + q2.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised up/down counter with programmable modulo, synchronous load, wrap or saturate mode, terminal-count pulse and an optional clock-enable prescaler. It replaces the fixed 4-bit counter behind the Tiny Tapeout top level. The top-level wrapper maps its `ui_in`/`uio_in` pins onto the control and data inputs, and its `uo_out` pins onto `count` and the flags.

## Interface
Parameters:
- `WIDTH`, default 8: counter width in bits, minimum 2.
- `PS_BITS`, default 4: prescaler width in bits. Used only when `COUNTER_PRESCALE_EN` is defined.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `en` input 1: count enable.
- `dir` input 1: direction. 1 = up, 0 = down.
- `sat` input 1: boundary mode. 1 = saturate, 0 = wrap.
- `load` input 1: synchronous load strobe.
- `load_val` input WIDTH: value to load.
- `modulo` input WIDTH: upper bound. The legal count range is 0..`modulo`.
- `prescale` input PS_BITS: tick divider, N = `prescale`+1. Present only with the macro.
- `count` output WIDTH: current count, registered.
- `tc` output 1: terminal-count pulse, registered, one cycle wide.
- `at_limit` output 1: combinational level. High when `count` sits at the boundary for the current `dir`.

## Operation
- **tick**: a qualified count event.
  - Without the macro: tick = `en`.
  - With the macro: see Configuration.
- **Priority**: `load` overrides tick in the same cycle.
  - `count` takes the value min(`load_val`, `modulo`).
  - `tc` is 0 on a load cycle.
- **Up tick** (`dir`=1):
  - If `count` < `modulo`: `count` + 1.
  - Otherwise, boundary event. Wrap mode: `count` becomes 0. Saturate mode: `count` becomes `modulo`.
- **Down tick** (`dir`=0):
  - If `count` > `modulo`: `count` becomes `modulo` in both modes. This case arises only after `modulo` has been lowered.
  - Else if `count` = 0: boundary event. Wrap mode: `count` becomes `modulo`. Saturate mode: `count` holds 0.
  - Otherwise: `count` − 1.
- **tc**: asserted in the cycle after every boundary event tick. This applies in both wrap and saturate modes, so a counter held in saturation pulses `tc` on every tick.
- **at_limit**:
  - `dir`=1: `count` >= `modulo`.
  - `dir`=0: `count` = 0.
- **Width rules**: all arithmetic is WIDTH-bit unsigned. `count` never exceeds `modulo` one cycle after any tick or load.
- **`modulo` = 0**: `count` stays 0. Every tick is a boundary event, so `tc` pulses on every tick.
- **`modulo` changed at run time**: takes effect on the next tick or load. No other state is touched.
- **`dir` or `sat` change**: applies to the tick in the same cycle. No history is kept.

## Timing
- **Reset** (`rst_n` low, asynchronous): `count` = 0, `tc` = 0, prescaler = 0. `at_limit` follows from `count` = 0: it is 1 if `dir`=0, or if `dir`=1 and `modulo`=0.
- **Reset release**: the first rising edge with `rst_n` high may count.
- **Reset mid-count**: the current state is discarded. No pending `tc` survives reset.
- **Latency**: a tick or load sampled at edge k appears on `count` after edge k. `tc` is valid over the same cycle as the post-wrap value.
- **Combinational path**: `at_limit` only. There are no other combinational input-to-output paths.

## Configuration
- **Macro**: `COUNTER_PRESCALE_EN`.
- **Defined**:
  - The `prescale` port and a PS_BITS-bit prescaler register `ps` exist.
  - `ps` advances only while `en`=1.
  - tick = `en` && (`ps` = `prescale`). On a tick, `ps` returns to 0.
  - `load` clears `ps` to 0.
  - `en`=0 freezes `ps`.
  - `prescale`=0 gives tick = `en`.
- **Undefined**:
  - No `prescale` port and no `ps` register.
  - tick = `en`.
  - Behaviour is cycle-identical to the defined case with `prescale`=0.

## Test plan
- **Reset**: assert `rst_n`=0 mid-count at `count`=5 with WIDTH=8 → `count`=0 and `tc`=0 immediately, without waiting for a clock edge. Release reset and hold `en`=1, `dir`=1 → `count`=1 after the first edge.
- **Wrap up**: `modulo`=9, `sat`=0, `dir`=1, `en`=1 from `count`=0 → sequence 0..9, then 0. `tc` is high only in the cycle `count` shows 0 after 9. `at_limit` is high while `count`=9.
- **Saturate down**: `modulo`=9, `sat`=1, `dir`=0, starting from `count`=2 → 1, 0, 0, 0. `tc` pulses on each tick at 0.
- **Load priority and clamp**:
  - `load`=1 with `load_val`=200, `modulo`=50 and `en`=1 → `count`=50, `tc`=0.
  - Then lower `modulo` to 20 with `dir`=1 → next tick gives `count`=0 in wrap mode, or 20 in saturate mode.
- **Prescaler** (macro defined, `prescale`=3):
  - `en`=1 continuously → `count` advances once every 4 cycles.
  - Drop `en` for 2 cycles mid-period → the period stretches by exactly 2 cycles.
  - `load` resets the phase to 0.
- **Edge values**: `modulo`=0 with `en`=1 → `count` stays 0 and `tc`=1 every cycle after the first tick. Also run WIDTH=2, `modulo`=3, `dir`=0 wrap → sequence 0, 3, 2, 1, 0.
